// File: rtl/fib_disp_pkg.sv
// fib_disp_pkg: shared FSM encoding, 7-segment codes and range helper for fib_bcd_display
package fib_disp_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ADD, ST_CONV, ST_DONE} state_e;

    // Active-low segment codes, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Largest value displayable on the given number of decimal digits
    function automatic int limit_of(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/fib_bcd_display_if.sv
// fib_bcd_display_if: step handshake, term outputs and display pins of fib_bcd_display
//   step  : request next term (master -> slave)
//   ready : slave idle, step will be honoured
//   valid : one-cycle pulse when num/bcd update
//   wrap  : one-cycle pulse with valid when the sequence restarted
//   num   : current term, binary
//   bcd   : current term, BCD, digit 0 in [3:0]
//   seg   : active-low segments {a..g}
//   an    : active-low one-hot anode select
interface fib_bcd_display_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic                  step;
    logic                  ready;
    logic                  valid;
    logic                  wrap;
    logic [WIDTH-1:0]      num;
    logic [4*DIGITS-1:0]   bcd;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (output step, input ready, valid, wrap, num, bcd, seg, an);
    modport slave  (input step, output ready, valid, wrap, num, bcd, seg, an);
endinterface

// File: rtl/seg7_enc.sv
// seg7_enc: BCD nibble to active-low 7-segment code, nibbles above 9 show a dash
//   d : nibble in
//   s : segment code {a..g}, active-low
module seg7_enc
    import fib_disp_pkg::*;
(
    input  logic [3:0] d,
    output logic [6:0] s
);
    always_comb begin
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/fib_bcd_display.sv
// fib_bcd_display: Fibonacci term generator with double-dabble BCD conversion and scanned 7-segment driver
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of fib_bcd_display_if (step/ready/valid/wrap/num/bcd/seg/an)
module fib_bcd_display
    import fib_disp_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
)(
    input  logic clk,
    input  logic reset,
    fib_bcd_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [WIDTH-1:0] LIM = WIDTH'(limit_of(DIGITS));

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ADD  = ST_ADD;
    localparam logic [1:0] CONV = ST_CONV;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]          state;
    logic [WIDTH-1:0]    a, b, num;
    logic [WIDTH:0]      sum;
    logic                flag, valid, wrap;
    logic [CW-1:0]       cnt;
    logic [BW+WIDTH-1:0] sr;
    logic [BW-1:0]       bcd, shifted;
    logic [SW-1:0]       div;
    logic [IW-1:0]       idx;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg, code;
    logic                blank;

    // Double-dabble correction: any nibble >= 5 gets +3 so the following shift carries into the next digit
    function automatic logic [BW-1:0] dd_adj(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return r;
    endfunction

    assign sum = {1'b0, a} + {1'b0, b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a     <= WIDTH'(1);
            b     <= WIDTH'(1);
            flag  <= 1'b0;
            cnt   <= '0;
            sr    <= '0;
            num   <= WIDTH'(1);
            bcd   <= BW'(1);
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            valid <= state == DONE;
            wrap  <= state == DONE && flag;
            case (state)
                IDLE: if (bus.step) state <= ADD;
                ADD: begin
                    if (b > LIM) begin
                        a    <= WIDTH'(1);
                        b    <= WIDTH'(1);
                        flag <= 1'b1;
                        sr   <= {BW'(0), WIDTH'(1)};
                    end else begin
                        a  <= b;
                        b  <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                        sr <= {BW'(0), b};
                    end
                    cnt   <= '0;
                    state <= CONV;
                end
                CONV: begin
                    sr  <= {dd_adj(sr[BW+WIDTH-1:WIDTH]), sr[WIDTH-1:0]} << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    num   <= a;
                    bcd   <= sr[BW+WIDTH-1:WIDTH];
                    flag  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shifting the BCD word down by the scan index puts the scanned digit in [3:0];
    // the digit is a leading zero exactly when that whole remainder is zero.
    assign shifted = bcd >> {idx, 2'b00};
    assign blank   = BLANK_LZ != 0 && idx != '0 && shifted == '0;

    seg7_enc u_enc (.d(shifted[3:0]), .s(code));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            idx <= '0;
            an  <= ~DIGITS'(1);
            seg <= SEG_1;
        end else begin
            if (div == SW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= blank ? SEG_BLANK : code;
        end
    end

    assign bus.ready = state == IDLE;
    assign bus.valid = valid;
    assign bus.wrap  = wrap;
    assign bus.num   = num;
    assign bus.bcd   = bcd;
    assign bus.seg   = seg;
    assign bus.an    = an;

endmodule

// File: doc/fib_bcd_display.md
# fib_bcd_display

Parametrised Fibonacci term generator with a sequential binary-to-BCD converter and a multiplexed, active-low 7-segment driver. It advances one term per accepted step request and wraps to the seed when a term exceeds the displayable range. Terms are exposed as binary, as BCD digits and as scanned segment/anode signals for a DIGITS-digit common-anode display. It sits between a step source (button debouncer or timer tick) and the board display pins.

## Interface
- WIDTH, 14: binary term width; must satisfy 2^WIDTH > 10^DIGITS − 1.
- DIGITS, 4: decimal digits displayed; LIMIT = 10^DIGITS − 1.
- SCAN_DIV, 1000: clock cycles each digit stays lit; ≥ 1.
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 never blanked).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- step  input  1  request the next term; honoured only while ready = 1.
- ready  output  1  high in IDLE.
- valid  output  1  one-cycle pulse when num/bcd update.
- wrap  output  1  one-cycle pulse coincident with valid when the sequence restarted.
- num  output  WIDTH  current term, binary.
- bcd  output  4·DIGITS  current term, BCD, digit 0 in bits [3:0].
- seg  output  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- an  output  DIGITS  anode select, one-hot active-low, registered.

## Operation
- Term pair (a, b) held internally; num shows a. Reset: a = 1, b = 1, num = 1, bcd = 0…01, ready = 1, valid = 0, wrap = 0, scan index 0, an = ~1, seg = code for "1".
- FSM states: IDLE, ADD, CONV, DONE.
- IDLE: step = 1 → ADD. Otherwise stay.
- ADD (1 cycle): if b > LIMIT then a ← 1, b ← 1, wrap flag set; else a ← b, b ← (a + b) computed at WIDTH+1 bits, saturated to all-ones on carry. Load shift register with the new a. → CONV.
- CONV (exactly WIDTH cycles): double-dabble. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit with the next binary MSB. → DONE after WIDTH shifts.
- DONE (1 cycle): num ← a, bcd ← converted digits, valid = 1, wrap = flag; flag cleared. → IDLE.
- step while ready = 0 is ignored, not queued.
- Sequence for DIGITS = 4: 1,1,2,3,5,8,…,4181,6765, then 1 with wrap, then 1,2,3,…
- Scanner runs independently of the FSM. A counter counts 0…SCAN_DIV−1. On terminal count the scan index advances modulo DIGITS. an and seg are registered from the index and from the bcd register, so a digit change appears on the next scan slot.
- Blanking (BLANK_LZ = 1): digit i > 0 outputs seg = 7'b1111111 when it and all higher digits are 0.
- Segment codes, active-low, in {a..g} order:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Nibbles above 9 give 1111110 (dash).

## Timing
- Step accepted at edge N → valid at edge N + WIDTH + 2 (ADD 1, CONV WIDTH, DONE 1). ready is low from N+1 until DONE completes.
- Minimum step-to-step period is WIDTH + 3 cycles.
- num and bcd change only in DONE and always together. Intermediate conversion values are never visible.
- Reset assertion at any time forces all reset values asynchronously and aborts any conversion; the interrupted step is lost.
- Simultaneous step and DONE: step is ignored, because ready is low in DONE.
- SCAN_DIV = 1 → index advances every cycle.

## Structure
- Package fib_disp_pkg holds:
  - the state enum;
  - the ten segment constants plus SEG_BLANK and SEG_DASH;
  - a function computing LIMIT from DIGITS.
- Sub-module seg7_enc: combinational 4-bit nibble to 7-bit active-low code, instantiated once on the scan path.

## Test plan
- Reset release, no step: num = 1, bcd = 16'h0001, ready = 1. With SCAN_DIV = 4, an cycles 1110→1101→1011→0111 every 4 clocks; digit 0 shows seg 1001111 and digits 1–3 show 1111111.
- 18 steps each waited to valid → num = 4181, bcd = 16'h4181. Each valid arrives exactly 16 cycles after its step (WIDTH = 14).
- Continue: step → 6765 with wrap = 0. Next step → num = 1 with wrap = 1. Next step → 1, then 2.
- Step held high continuously → one advance per 17 cycles; no term is skipped or doubled.
- Reset pulsed 5 cycles into CONV after reaching 144 → num = 1 immediately; after release no valid pulse occurs until a new step.
- BLANK_LZ = 0, term 89 → an scan shows digits 0,0,8,9 with seg 0000001, 0000001, 0000000, 0000100.
